// File: rtl/time_counter_if.sv
// time_counter bus: 1 Hz tick and button strobes in, BCD time, set-mode state, chime out.
// master drives strobes and reads the time; slave is the counter.
interface time_counter_if;
  logic       tick_1hz;
  logic       mode_btn;
  logic       inc_btn;
  logic [7:0] hour_bcd;
  logic [7:0] min_bcd;
  logic [7:0] sec_bcd;
  logic [1:0] state;
  logic       chime;

  modport master (
    output tick_1hz, mode_btn, inc_btn,
    input  hour_bcd, min_bcd, sec_bcd,
    input  state, chime
  );

  modport slave (
    input  tick_1hz, mode_btn, inc_btn,
    output hour_bcd, min_bcd, sec_bcd,
    output state, chime
  );
endinterface

// File: rtl/time_counter.sv
// 24h BCD hh:mm:ss counter with RUN/SET_HOUR/SET_MIN set-mode FSM and hourly chime.
// Ports: CP clock, _CR async active-low reset, bus (slave) strobes in / registered time out.
module time_counter #(
  parameter int unsigned CHIME_LEN = 5
) (
  input  logic          CP,
  input  logic          _CR,
  time_counter_if.slave bus
);
  typedef enum logic [1:0] {
    RUN      = 2'b00,
    SET_HOUR = 2'b01,
    SET_MIN  = 2'b10
  } state_t;

  localparam logic [6:0] CLEN = 7'(CHIME_LEN);

  state_t     st_q, st_d;
  logic [7:0] hr_q, mn_q, sc_q;
  logic [7:0] hr_d, mn_d, sc_d;
  logic       ch_q, ch_d;
  logic [8:0] s_inc, m_inc, h_inc;
  logic [6:0] sec_bin;

  // {carry, next} for a two-digit BCD field wrapping at lim
  function automatic logic [8:0] bcd_inc(
    input logic [7:0] v,
    input logic [7:0] lim
  );
    logic [8:0] r;
    if (v == lim)
      r = 9'h100;
    else if (v[3:0] == 4'd9)
      r = {1'b0, v[7:4] + 4'd1, 4'd0};
    else
      r = {1'b0, v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  always_comb begin
    s_inc = bcd_inc(sc_q, 8'h59);
    m_inc = bcd_inc(mn_q, 8'h59);
    h_inc = bcd_inc(hr_q, 8'h23);
  end

  always_comb begin
    st_d = st_q;
    hr_d = hr_q;
    mn_d = mn_q;
    sc_d = sc_q;
    case (st_q)
      RUN: begin
        if (bus.tick_1hz) begin
          sc_d = s_inc[7:0];
          if (s_inc[8]) begin
            mn_d = m_inc[7:0];
            if (m_inc[8])
              hr_d = h_inc[7:0];
          end
        end
        if (bus.mode_btn)
          st_d = SET_HOUR;
      end
      SET_HOUR: begin
        if (bus.mode_btn)
          st_d = SET_MIN;
        else if (bus.inc_btn)
          hr_d = h_inc[7:0];
      end
      SET_MIN: begin
        if (bus.mode_btn) begin
          st_d = RUN;
          sc_d = 8'h00;
        end else if (bus.inc_btn) begin
          mn_d = m_inc[7:0];
        end
      end
      default: st_d = RUN;
    endcase
  end

  // chime looks at the time being loaded, so it rises with 00:00
  always_comb begin
    sec_bin = {3'b0, sc_d[7:4]} * 7'd10
            + {3'b0, sc_d[3:0]};
    ch_d = (st_d == RUN)
        && (mn_d == 8'h00)
        && (sec_bin < CLEN);
  end

  always_ff @(posedge CP or negedge _CR) begin
    if (!_CR) begin
      st_q <= RUN;
      hr_q <= 8'h00;
      mn_q <= 8'h00;
      sc_q <= 8'h00;
      ch_q <= 1'b0;
    end else begin
      st_q <= st_d;
      hr_q <= hr_d;
      mn_q <= mn_d;
      sc_q <= sc_d;
      ch_q <= ch_d;
    end
  end

  assign bus.hour_bcd = hr_q;
  assign bus.min_bcd  = mn_q;
  assign bus.sec_bcd  = sc_q;
  assign bus.state    = st_q;
  assign bus.chime    = ch_q;
endmodule

// File: tb/tb_time_counter.sv
// Scoreboard bench for time_counter: CHIME_LEN 5, 0 and 59 instances
// share one stimulus stream; a negedge monitor pops expected values.
module tb_time_counter;
  logic clk;
  logic rst_n;
  logic tck, mbt, ibt;

  time_counter_if bus5();
  time_counter_if bus0();
  time_counter_if bus59();

  assign bus5.tick_1hz  = tck;
  assign bus5.mode_btn  = mbt;
  assign bus5.inc_btn   = ibt;
  assign bus0.tick_1hz  = tck;
  assign bus0.mode_btn  = mbt;
  assign bus0.inc_btn   = ibt;
  assign bus59.tick_1hz = tck;
  assign bus59.mode_btn = mbt;
  assign bus59.inc_btn  = ibt;

  time_counter #(.CHIME_LEN(5)) dut5 (
    .CP(clk), ._CR(rst_n), .bus(bus5.slave)
  );
  time_counter #(.CHIME_LEN(0)) dut0 (
    .CP(clk), ._CR(rst_n), .bus(bus0.slave)
  );
  time_counter #(.CHIME_LEN(59)) dut59 (
    .CP(clk), ._CR(rst_n), .bus(bus59.slave)
  );

  typedef struct {
    logic       chk;
    logic [7:0] h, m, s;
    logic [1:0] st;
    logic       ch;
  } exp_t;

  exp_t q[$];
  int tests = 0;
  int fails = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string nm,
    input logic [7:0] act,
    input logic [7:0] req
  );
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h want %h at %0t",
               nm, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    logic c59;
    if (rst_n) begin
      tests++;
      if (bus5.hour_bcd[3:0] > 4'd9 ||
          bus5.hour_bcd[7:4] > 4'd2 ||
          bus5.min_bcd[3:0] > 4'd9 ||
          bus5.min_bcd[7:4] > 4'd5 ||
          bus5.sec_bcd[3:0] > 4'd9 ||
          bus5.sec_bcd[7:4] > 4'd5) begin
        fails++;
        $display("FAIL digit: got %h:%h:%h want BCD",
                 bus5.hour_bcd, bus5.min_bcd,
                 bus5.sec_bcd);
      end
    end
    if (q.size() > 0) begin
      e = q.pop_front();
      if (e.chk) begin
        c59 = (e.st == 2'd0) && (e.m == 8'h00)
           && (e.s <= 8'h58);
        check("hour", bus5.hour_bcd, e.h);
        check("min", bus5.min_bcd, e.m);
        check("sec", bus5.sec_bcd, e.s);
        check("state", {6'd0, bus5.state}, {6'd0, e.st});
        check("chime5", {7'd0, bus5.chime}, {7'd0, e.ch});
        check("chime0", {7'd0, bus0.chime}, 8'd0);
        check("chime59", {7'd0, bus59.chime}, {7'd0, c59});
      end
    end
  end

  task automatic cyc(
    input logic t, input logic m, input logic i,
    input logic c,
    input logic [7:0] eh, input logic [7:0] em,
    input logic [7:0] es, input logic [1:0] est,
    input logic ech
  );
    exp_t e;
    @(negedge clk);
    tck = t;
    mbt = m;
    ibt = i;
    @(posedge clk);
    #1;
    e.chk = c;
    e.h = eh;
    e.m = em;
    e.s = es;
    e.st = est;
    e.ch = ech;
    q.push_back(e);
  endtask

  task automatic ticks(input int n);
    repeat (n) cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic incs(input int n);
    repeat (n) cyc(0, 0, 1, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic mode1();
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic chk_rst();
    check("rst_hour", bus5.hour_bcd, 8'h00);
    check("rst_min", bus5.min_bcd, 8'h00);
    check("rst_sec", bus5.sec_bcd, 8'h00);
    check("rst_state", {6'd0, bus5.state}, 8'd0);
    check("rst_chime", {7'd0, bus5.chime}, 8'd0);
    check("rst_chime59", {7'd0, bus59.chime}, 8'd0);
  endtask

  initial begin
    logic [7:0] eh, es, em;
    logic ech;
    tck = 0;
    mbt = 0;
    ibt = 0;
    rst_n = 1'b1;
    #3 rst_n = 1'b0;
    #1 chk_rst();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    cyc(0, 0, 0, 1, 8'h00, 8'h00, 8'h00, 2'd0, 1);
    cyc(1, 0, 0, 1, 8'h00, 8'h00, 8'h01, 2'd0, 1);
    cyc(0, 1, 0, 1, 8'h00, 8'h00, 8'h01, 2'd1, 0);
    for (int i = 1; i <= 25; i++) begin
      eh = (i == 23) ? 8'h23 : (i == 24) ? 8'h00 : 8'h01;
      cyc(0, 0, 1, i >= 23, eh, 8'h00, 8'h01, 2'd1, 0);
    end
    cyc(1, 0, 0, 1, 8'h01, 8'h00, 8'h01, 2'd1, 0);
    cyc(0, 1, 0, 1, 8'h01, 8'h00, 8'h01, 2'd2, 0);
    for (int i = 1; i <= 61; i++) begin
      em = (i == 59) ? 8'h59 : (i == 60) ? 8'h00 : 8'h01;
      cyc(0, 0, 1, i >= 59, 8'h01, em, 8'h01, 2'd2, 0);
    end
    cyc(1, 0, 0, 1, 8'h01, 8'h01, 8'h01, 2'd2, 0);
    cyc(1, 1, 0, 1, 8'h01, 8'h01, 8'h00, 2'd0, 0);
    cyc(0, 1, 0, 1, 8'h01, 8'h01, 8'h00, 2'd1, 0);
    cyc(0, 1, 1, 1, 8'h01, 8'h01, 8'h00, 2'd2, 0);
    cyc(0, 1, 0, 1, 8'h01, 8'h01, 8'h00, 2'd0, 0);

    mode1();
    incs(8);
    mode1();
    incs(8);
    cyc(0, 1, 0, 1, 8'h09, 8'h09, 8'h00, 2'd0, 0);
    ticks(58);
    cyc(1, 0, 0, 1, 8'h09, 8'h09, 8'h59, 2'd0, 0);
    cyc(1, 0, 0, 1, 8'h09, 8'h10, 8'h00, 2'd0, 0);

    mode1();
    incs(10);
    mode1();
    incs(49);
    cyc(0, 1, 0, 1, 8'h19, 8'h59, 8'h00, 2'd0, 0);
    ticks(58);
    cyc(1, 0, 0, 1, 8'h19, 8'h59, 8'h59, 2'd0, 0);
    cyc(1, 0, 0, 1, 8'h20, 8'h00, 8'h00, 2'd0, 1);

    cyc(0, 1, 0, 1, 8'h20, 8'h00, 8'h00, 2'd1, 0);
    incs(13);
    cyc(0, 0, 1, 1, 8'h10, 8'h00, 8'h00, 2'd1, 0);
    mode1();
    cyc(0, 1, 0, 1, 8'h10, 8'h00, 8'h00, 2'd0, 1);
    ticks(6);
    cyc(1, 0, 0, 1, 8'h10, 8'h00, 8'h07, 2'd0, 0);
    cyc(1, 1, 0, 1, 8'h10, 8'h00, 8'h08, 2'd1, 0);

    incs(12);
    cyc(0, 0, 1, 1, 8'h23, 8'h00, 8'h08, 2'd1, 0);
    mode1();
    incs(58);
    cyc(0, 0, 1, 1, 8'h23, 8'h59, 8'h08, 2'd2, 0);
    cyc(0, 1, 0, 1, 8'h23, 8'h59, 8'h00, 2'd0, 0);
    ticks(58);
    cyc(1, 0, 0, 1, 8'h23, 8'h59, 8'h59, 2'd0, 0);
    for (int i = 0; i <= 60; i++) begin
      es = (i == 60) ? 8'h00 : {4'(i / 10), 4'(i % 10)};
      em = (i == 60) ? 8'h01 : 8'h00;
      ech = (i < 5);
      cyc(1, 0, 0, 1, 8'h00, em, es, 2'd0, ech);
    end

    mode1();
    incs(12);
    mode1();
    incs(33);
    cyc(0, 1, 0, 1, 8'h12, 8'h34, 8'h00, 2'd0, 0);
    ticks(55);
    cyc(1, 0, 0, 1, 8'h12, 8'h34, 8'h56, 2'd0, 0);
    cyc(0, 0, 0, 1, 8'h12, 8'h34, 8'h56, 2'd0, 0);

    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_rst();
    @(negedge clk);
    rst_n = 1'b1;
    cyc(0, 0, 0, 1, 8'h00, 8'h00, 8'h00, 2'd0, 1);
    cyc(0, 0, 0, 1, 8'h00, 8'h00, 8'h00, 2'd0, 1);
    cyc(1, 0, 0, 1, 8'h00, 8'h00, 8'h01, 2'd0, 1);

    for (int k = 0; k < 5 && q.size() > 0; k++)
      @(negedge clk);
    #1;
    tests++;
    if (q.size() > 0) begin
      fails++;
      $display("FAIL drain: got %0d left want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
